// File: rtl/frame_sched.sv
// Frame-granular round-robin scheduler sharing one downstream datapath between two pixel sources.
// A grant lasts FRAME_WORDS accepted words plus the write-back completion handshake.
module frame_sched #(
  parameter int DW          = 32,
  parameter int FRAME_WORDS = 16,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    slv0_mode,
  input  logic [1:0]    slv1_mode,
  input  logic          slv0_data_valid,
  input  logic          slv1_data_valid,
  input  logic [7:0]    slv0_proc_valid,
  input  logic [7:0]    slv1_proc_valid,
  input  logic [DW-1:0] slv0_data,
  input  logic [DW-1:0] slv1_data,
  input  logic          fifo_full,
  input  logic          mstr0_cmplt,
  output logic          slv0_ready,
  output logic          slv1_ready,
  output logic [1:0]    slvx_mode,
  output logic          slvx_data_valid,
  output logic [7:0]    slvx_proc_val,
  output logic [DW-1:0] slvx_data,
  output logic          active_slv,
  output logic          frame_done
);

  // Handshake: a word moves when slvN_data_valid and slvN_ready are both high at a
  // rising edge; ready never depends on valid, and a waiting source holds its word.
  typedef enum logic [1:0] {IDLE, XFER, WAIT_CMPLT} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             grant_req;
  logic             grant_slv;
  logic             xfer;
  logic             last_word;

  always_comb begin
    grant_req  = slv0_data_valid | slv1_data_valid;
    // On a tie the slave that did not win last time is served.
    grant_slv  = (slv0_data_valid & slv1_data_valid) ? ~last_grant : slv1_data_valid;
    slv0_ready = (state == XFER) & ~active_slv & ~fifo_full;
    slv1_ready = (state == XFER) &  active_slv & ~fifo_full;
    xfer       = active_slv ? (slv1_ready & slv1_data_valid) : (slv0_ready & slv0_data_valid);
    last_word  = xfer & (cnt == LAST_CNT);
    state_nxt  = state;
    case (state)
      IDLE:       if (grant_req)   state_nxt = XFER;
      XFER:       if (last_word)   state_nxt = WAIT_CMPLT;
      WAIT_CMPLT: if (mstr0_cmplt) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      last_grant      <= 1'b1;
      active_slv      <= 1'b0;
      slvx_mode       <= 2'b00;
      slvx_data_valid <= 1'b0;
      slvx_proc_val   <= 8'h00;
      slvx_data       <= '0;
      frame_done      <= 1'b0;
    end else begin
      slvx_data_valid <= xfer;
      frame_done      <= (state == WAIT_CMPLT) & mstr0_cmplt;
      if ((state == IDLE) && grant_req) begin
        active_slv <= grant_slv;
        last_grant <= grant_slv;
        slvx_mode  <= grant_slv ? slv1_mode : slv0_mode;
        cnt        <= '0;
      end
      if (xfer) begin
        slvx_data     <= active_slv ? slv1_data : slv0_data;
        slvx_proc_val <= active_slv ? slv1_proc_valid : slv0_proc_valid;
        cnt           <= last_word ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched: scoreboard of forwarded words plus grant/mode/completion checks.
module tb_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  slv0_mode, slv1_mode;
  logic        slv0_data_valid, slv1_data_valid;
  logic [7:0]  slv0_proc_valid, slv1_proc_valid;
  logic [31:0] slv0_data, slv1_data;
  logic        fifo_full, mstr0_cmplt;
  logic        slv0_ready, slv1_ready;
  logic [1:0]  slvx_mode;
  logic        slvx_data_valid;
  logic [7:0]  slvx_proc_val;
  logic [31:0] slvx_data;
  logic        active_slv, frame_done;

  int errors = 0;
  int checks = 0;
  int vld_cnt = 0;
  int done_cnt = 0;
  logic [39:0] exp_q[$];

  frame_sched #(.DW(32), .FRAME_WORDS(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .slv0_mode(slv0_mode), .slv1_mode(slv1_mode),
    .slv0_data_valid(slv0_data_valid), .slv1_data_valid(slv1_data_valid),
    .slv0_proc_valid(slv0_proc_valid), .slv1_proc_valid(slv1_proc_valid),
    .slv0_data(slv0_data), .slv1_data(slv1_data),
    .fifo_full(fifo_full), .mstr0_cmplt(mstr0_cmplt),
    .slv0_ready(slv0_ready), .slv1_ready(slv1_ready),
    .slvx_mode(slvx_mode), .slvx_data_valid(slvx_data_valid),
    .slvx_proc_val(slvx_proc_val), .slvx_data(slvx_data),
    .active_slv(active_slv), .frame_done(frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (slvx_data_valid) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected: observed word=%0h expected=none", slvx_data);
        end else begin
          chk("sb_word", {24'h0, slvx_proc_val, slvx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  // driver tasks
  task automatic set_src(input bit s, input logic v, input logic [31:0] d);
    if (s) begin
      slv1_data_valid = v; slv1_data = d; slv1_proc_valid = d[7:0] ^ 8'h5a;
    end else begin
      slv0_data_valid = v; slv0_data = d; slv0_proc_valid = d[7:0] ^ 8'h5a;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rdy0"}, slv0_ready, 0);
    chk({tag, "_rdy1"}, slv1_ready, 0);
    chk({tag, "_mode"}, slvx_mode, 0);
    chk({tag, "_dv"},   slvx_data_valid, 0);
    chk({tag, "_pv"},   slvx_proc_val, 0);
    chk({tag, "_data"}, slvx_data, 0);
    chk({tag, "_act"},  active_slv, 0);
    chk({tag, "_done"}, frame_done, 0);
  endtask

  // Drive n words base..base+n-1 from slave s; optional stall/gap/mode change/early cmplt.
  task automatic send_frame(input bit s, input logic [31:0] base, input int n,
                            input int stall_at, input int gap_at,
                            input int mode_at, input logic [1:0] new_mode,
                            input int cmplt_at);
    logic [31:0] d;
    logic        rdy;
    int          waits;
    for (int i = 0; i < n; i++) begin
      d = base + 32'(i);
      if (i == gap_at) begin
        if (s) slv1_data_valid = 1'b0; else slv0_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      if (i == mode_at) begin
        if (s) slv1_mode = new_mode; else slv0_mode = new_mode;
      end
      if (i == stall_at) begin
        fifo_full = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready", s ? slv1_ready : slv0_ready, 0);
        end
        @(posedge clk);
        #1;
        fifo_full = 1'b0;
      end
      set_src(s, 1'b1, d);
      if (i == cmplt_at) mstr0_cmplt = 1'b1;
      waits = 0;
      do begin
        @(negedge clk);
        rdy = s ? slv1_ready : slv0_ready;
        waits++;
      end while (!rdy && waits < 50);
      if (!rdy) begin
        chk("accept_timeout", rdy, 1);
        mstr0_cmplt = 1'b0;
        return;
      end
      exp_q.push_back({d[7:0] ^ 8'h5a, d});
      @(posedge clk);
      #1;
      mstr0_cmplt = 1'b0;
    end
  endtask

  // After the last accept: WAIT_CMPLT holds ready low and all words have come out.
  task automatic check_frame_end(input bit s, input int vld_start, input int n,
                                 input logic [1:0] mode_exp);
    @(negedge clk);
    chk("wait_ready", s ? slv1_ready : slv0_ready, 0);
    @(posedge clk);
    #1;
    chk("word_count", 64'(vld_cnt - vld_start), 64'(n));
    chk("sb_empty", 64'(exp_q.size()), 0);
    chk("active_slv", active_slv, s);
    chk("frame_mode", slvx_mode, mode_exp);
    chk("wait_dv", slvx_data_valid, 0);
  endtask

  task automatic complete(input int done_before);
    chk("no_early_done", 64'(done_cnt), 64'(done_before));
    mstr0_cmplt = 1'b1;
    @(posedge clk);
    #1;
    mstr0_cmplt = 1'b0;
    chk("done_pulse", frame_done, 1);
    @(posedge clk);
    #1;
    chk("done_clear", frame_done, 0);
  endtask

  int vs;

  initial begin
    rst_n = 1'b0;
    slv0_mode = 2'b10; slv1_mode = 2'b11;
    set_src(0, 1'b0, 32'h0);
    set_src(1, 1'b0, 32'h0);
    fifo_full = 1'b0; mstr0_cmplt = 1'b0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Slave 0 alone: early cmplt at word 3, stall at 5, mode change at 8, valid gap at 12.
    vs = vld_cnt;
    send_frame(0, 32'h1, 16, 5, 12, 8, 2'b01, 3);
    check_frame_end(0, vs, 16, 2'b10);
    slv0_data_valid = 1'b0;
    complete(0);

    // Round-robin with both requesting from reset.
    rst_n = 1'b0;
    slv0_data_valid = 1'b1;
    slv1_data_valid = 1'b1;
    slv1_data = 32'hdead_0000;
    #3;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    vs = vld_cnt;
    send_frame(0, 32'h100, 16, -1, -1, -1, 2'b00, -1);
    check_frame_end(0, vs, 16, 2'b01);
    complete(0);
    vs = vld_cnt;
    send_frame(1, 32'h200, 16, -1, -1, -1, 2'b00, -1);
    check_frame_end(1, vs, 16, 2'b11);
    complete(1);
    vs = vld_cnt;
    send_frame(0, 32'h300, 16, -1, -1, -1, 2'b00, -1);
    check_frame_end(0, vs, 16, 2'b01);
    slv0_data_valid = 1'b0;
    slv1_data_valid = 1'b0;
    complete(2);

    // Asynchronous reset after word 10, then a full fresh frame.
    do_reset();
    done_cnt = 0;
    send_frame(0, 32'h400, 10, -1, -1, -1, 2'b00, -1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    slv0_data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vs = vld_cnt;
    send_frame(0, 32'h500, 16, -1, -1, -1, 2'b00, -1);
    check_frame_end(0, vs, 16, 2'b01);
    slv0_data_valid = 1'b0;
    complete(0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_sched.md
Name: frame_sched

Overview:
Frame-granular scheduler that shares the downstream processing/FIFO datapath between two pixel sources (slave 0 and slave 1) in the image-processing accelerator. It grants one slave for a whole frame of FRAME_WORDS words and latches that slave's mode for the frame. It forwards words on the slvx_* bus under fifo_full backpressure, then waits for mstr0_cmplt (write-back done) before re-arbitrating round-robin.

Parameters:
DW, 32, pixel data word width
FRAME_WORDS, 16, words per frame (>=2)
CNT_W, 16, frame word counter width; must satisfy 2^CNT_W >= FRAME_WORDS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
slv0_mode  input  2  slave 0 processing mode
slv1_mode  input  2  slave 1 processing mode
slv0_data_valid  input  1  slave 0 word valid; also acts as its request
slv1_data_valid  input  1  slave 1 word valid; also acts as its request
slv0_proc_valid  input  8  slave 0 per-byte/lane process enables
slv1_proc_valid  input  8  slave 1 per-byte/lane process enables
slv0_data  input  DW  slave 0 data
slv1_data  input  DW  slave 1 data
fifo_full  input  1  downstream FIFO full (backpressure)
mstr0_cmplt  input  1  downstream master finished current frame write-back
slv0_ready  output  1  slave 0 word accepted this cycle when high with valid
slv1_ready  output  1  slave 1 word accepted this cycle when high with valid
slvx_mode  output  2  latched mode of granted slave
slvx_data_valid  output  1  forwarded word valid
slvx_proc_val  output  8  forwarded proc_valid
slvx_data  output  DW  forwarded data
active_slv  output  1  current/last granted slave index
frame_done  output  1  one-cycle pulse when a frame is closed by mstr0_cmplt

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, last_grant=1 (slave 0 wins first tie), all outputs 0, including active_slv.
- States: IDLE, XFER, WAIT_CMPLT.
- IDLE: if exactly one data_valid is high, grant that slave. If both are high, grant the slave != last_grant. On grant: latch slvx_mode <= granted slvN_mode, active_slv <= N, last_grant <= N, counter <= 0, go to XFER. No word is accepted in the grant cycle; ready=0 in IDLE.
- XFER: slvN_ready = (active_slv==N) & !fifo_full, combinational. The non-granted ready is 0.
- Transfer = granted ready & granted data_valid. On transfer, register slvx_data, slvx_proc_val and slvx_data_valid=1 on the next edge (1-cycle latency). Otherwise slvx_data_valid=0 next cycle, and data/proc_val hold their last values.
- Counter increments per transfer. A transfer with counter==FRAME_WORDS-1 is the last word: go to WAIT_CMPLT and reset counter to 0.
- fifo_full high: ready low the same cycle, no transfer, counter holds. Granted slave dropping valid mid-frame: stall; the grant is not released.
- The slvx_mode latch is stable for the entire frame. Slave mode changes mid-frame are ignored.
- WAIT_CMPLT: ready=0, slvx_data_valid=0 (after the final word's valid cycle). On mstr0_cmplt=1: frame_done=1 for one cycle, go to IDLE. Re-arbitration happens in IDLE the following cycle.
- mstr0_cmplt in IDLE or XFER is ignored.
- active_slv and slvx_mode hold until the next grant.
- Async reset mid-frame aborts immediately: partial frame discarded, all outputs 0.
- Simultaneous last transfer and mstr0_cmplt in the same cycle: cmplt ignored (state was XFER); a new cmplt is needed in WAIT_CMPLT.

Test Plan:
- Reset then slv0_data_valid=1, slv0_mode=2'b10, 16 words 32'h00000001..32'h00000010 -> grant after 1 cycle; slvx_mode=2'b10; slvx_data equals each word 1 cycle after accept; 16 slvx_data_valid pulses; slv0_ready=0 in WAIT_CMPLT; mstr0_cmplt -> frame_done 1-cycle pulse.
- Both valids high from reset -> slave 0 frame first; after cmplt, slave 1 granted (active_slv=1); after next cmplt with both still requesting, slave 0 again.
- fifo_full=1 for 3 cycles at word 5 -> slv0_ready=0 those 3 cycles, counter stays at 5, no slvx_data_valid, no word lost or duplicated; frame still ends after exactly 16 words.
- slv0_mode changed 2'b10->2'b01 at word 8 -> slvx_mode stays 2'b10 for the frame; 2'b01 is taken at the next grant.
- mstr0_cmplt pulsed during XFER at word 3 -> no frame_done, transfer continues; cmplt in WAIT_CMPLT -> frame_done.
- rst_n low at word 10 -> all outputs 0 asynchronously; after release, a fresh 16-word frame is required before WAIT_CMPLT.
